// File: rtl/alsu_req_arbiter_if.sv
// Requester-side bus of the ALSU arbiter: two command channels and two response channels.
// The requester side (master) drives commands and rsp_ready; the arbiter (slave) answers.
interface alsu_req_arbiter_if;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [15:0] req0_cmd, req1_cmd;
  logic        rsp0_valid, rsp0_ready, rsp0_err;
  logic        rsp1_valid, rsp1_ready, rsp1_err;
  logic [5:0]  rsp0_out, rsp1_out;

  modport master (
    output req0_valid, req0_cmd, req1_valid, req1_cmd, rsp0_ready, rsp1_ready,
    input  req0_ready, req1_ready, rsp0_valid, rsp0_out, rsp0_err,
           rsp1_valid, rsp1_out, rsp1_err
  );

  modport slave (
    input  req0_valid, req0_cmd, req1_valid, req1_cmd, rsp0_ready, rsp1_ready,
    output req0_ready, req1_ready, rsp0_valid, rsp0_out, rsp0_err,
           rsp1_valid, rsp1_out, rsp1_err
  );
endinterface

// File: rtl/alsu_req_arbiter.sv
// Two-requester front end for a single ALSU: round-robin (or fixed) grant, one command in
// flight, fixed pipeline wait, result returned only to the requester that issued it.
module alsu_req_arbiter #(
  parameter int    ALSU_LAT = 2,
  parameter string RR_EN    = "ON"
) (
  input  logic              clk,
  input  logic              rst_n,
  alsu_req_arbiter_if.slave bus,
  output logic              alsu_rst,
  output logic              alsu_red_op_A,
  output logic              alsu_red_op_B,
  output logic              alsu_bypass_A,
  output logic              alsu_bypass_B,
  output logic              alsu_direction,
  output logic              alsu_serial_in,
  output logic              alsu_cin,
  output logic [2:0]        alsu_opcode,
  output logic [2:0]        alsu_A,
  output logic [2:0]        alsu_B,
  input  logic [5:0]        alsu_out,
  input  logic [15:0]       alsu_leds
);
  localparam bit RR_ON = (RR_EN == "ON");
  localparam int CW    = (ALSU_LAT > 1) ? $clog2(ALSU_LAT) : 1;

  typedef enum logic [2:0] {S_INIT, S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t          r_state, w_next;
  logic [15:0]     r_cmd;
  logic            r_gnt, r_last, r_err;
  logic [CW-1:0]   r_cnt;
  logic [5:0]      r_out;
  logic            w_gnt, w_any, w_acc, w_hs, w_done;

  // r_last is the id granted last; both valid -> the other one wins
  always_comb begin
    w_gnt = 1'b0;
    if (bus.req0_valid && bus.req1_valid) w_gnt = RR_ON ? ~r_last : 1'b0;
    else if (bus.req1_valid)              w_gnt = 1'b1;
  end

  assign w_any  = bus.req0_valid | bus.req1_valid;
  assign w_acc  = (r_state == S_IDLE) && w_any;
  assign w_hs   = (r_state == S_RESP) && (r_gnt ? bus.rsp1_ready : bus.rsp0_ready);
  assign w_done = (r_cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_INIT;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_INIT:  w_next = S_IDLE;
      S_IDLE:  if (w_any)  w_next = S_ISSUE;
      S_ISSUE: w_next = S_WAIT;
      S_WAIT:  if (w_done) w_next = S_RESP;
      S_RESP:  if (w_hs)   w_next = S_IDLE;
      default: w_next = S_INIT;
    endcase
  end

  always_comb begin
    alsu_rst       = (r_state == S_INIT);
    bus.req0_ready = w_acc & bus.req0_valid & ~w_gnt;
    bus.req1_ready = w_acc & bus.req1_valid &  w_gnt;
    bus.rsp0_valid = (r_state == S_RESP) & ~r_gnt;
    bus.rsp1_valid = (r_state == S_RESP) &  r_gnt;
    bus.rsp0_out   = r_gnt ? '0 : r_out;
    bus.rsp1_out   = r_gnt ? r_out : '0;
    bus.rsp0_err   = ~r_gnt & r_err;
    bus.rsp1_err   =  r_gnt & r_err;
  end

  // r_cmd doubles as the ALSU input register: stable from ISSUE until the next accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cmd  <= '0;
      r_gnt  <= 1'b0;
      r_last <= 1'b1;
      r_cnt  <= '0;
      r_out  <= '0;
      r_err  <= 1'b0;
    end else begin
      if (w_acc) begin
        r_cmd  <= w_gnt ? bus.req1_cmd : bus.req0_cmd;
        r_gnt  <= w_gnt;
        r_last <= w_gnt;
      end
      if (r_state == S_ISSUE) r_cnt <= CW'(ALSU_LAT - 1);
      if (r_state == S_WAIT) begin
        if (w_done) begin
          r_out <= alsu_out;
          r_err <= |alsu_leds;
        end else begin
          r_cnt <= r_cnt - 1'b1;
        end
      end
    end
  end

  assign {alsu_red_op_A, alsu_red_op_B, alsu_bypass_A, alsu_bypass_B, alsu_direction,
          alsu_serial_in, alsu_cin, alsu_opcode, alsu_A, alsu_B} = r_cmd;
endmodule

// File: tb/tb_alsu_req_arbiter.sv
// Bench for alsu_req_arbiter: instance 0 (LAT=2, round-robin), instance 1 (LAT=3, fixed
// priority), each driving a small behavioural ALSU with matching pipeline depth.
module tb_alsu_req_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]       r0v = '0, r1v = '0, s0r = '1, s1r = '1;
  logic [1:0][15:0] r0c = '0, r1c = '0;
  wire  [1:0]       q0r, q1r, p0v, p1v, e0, e1, a_rst;
  wire  [1:0][5:0]  o0, o1;
  wire  [1:0][2:0]  a_op;

  int n_chk = 0, n_err = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  localparam logic [2:0] OP_OR = 3'd0, OP_ADD = 3'd2, OP_MUL = 3'd3, OP_BAD = 3'd7;

  function automatic logic [15:0] mk(input logic [2:0] op, input logic [2:0] a,
                                     input logic [2:0] b, input logic cin);
    return {6'b0, cin, op, a, b};
  endfunction

  function automatic logic [5:0] alsu_f(input logic [15:0] c, input logic [5:0] prev);
    logic [5:0] sa, sb;
    sa = {{3{c[5]}}, c[5:3]};
    sb = {{3{c[2]}}, c[2:0]};
    if (c[13]) return sa;
    if (c[12]) return sb;
    case (c[8:6])
      3'd0:    return sa | sb;
      3'd1:    return sa ^ sb;
      3'd2:    return sa + sb + {5'b0, c[9]};
      3'd3:    return sa * sb;
      3'd4:    return c[11] ? {prev[4:0], c[10]} : {c[10], prev[5:1]};
      3'd5:    return c[11] ? {prev[4:0], prev[5]} : {prev[0], prev[5:1]};
      default: return '0;
    endcase
  endfunction

  function automatic logic alsu_e(input logic [15:0] c);
    return (c[8:7] == 2'b11) || ((c[15] || c[14]) && (c[8:6] > 3'd1));
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int    LAT = (g == 0) ? 2 : 3;
    localparam string RRS = (g == 0) ? "ON" : "OFF";
    alsu_req_arbiter_if bus ();
    logic             rA, rB, bA, bB, dir, sin, cin;
    logic [2:0]       A, B;
    logic [5:0]       aout;
    logic [15:0]      leds;
    logic [LAT-1:0][5:0] p_out;
    logic [LAT-1:0]      p_err;
    wire  [15:0]      w_c = {rA, rB, bA, bB, dir, sin, cin, a_op[g], A, B};

    assign bus.req0_valid = r0v[g];
    assign bus.req0_cmd   = r0c[g];
    assign bus.req1_valid = r1v[g];
    assign bus.req1_cmd   = r1c[g];
    assign bus.rsp0_ready = s0r[g];
    assign bus.rsp1_ready = s1r[g];
    assign q0r[g] = bus.req0_ready;
    assign q1r[g] = bus.req1_ready;
    assign p0v[g] = bus.rsp0_valid;
    assign p1v[g] = bus.rsp1_valid;
    assign o0[g]  = bus.rsp0_out;
    assign o1[g]  = bus.rsp1_out;
    assign e0[g]  = bus.rsp0_err;
    assign e1[g]  = bus.rsp1_err;

    alsu_req_arbiter #(.ALSU_LAT(LAT), .RR_EN(RRS)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus),
      .alsu_rst(a_rst[g]), .alsu_red_op_A(rA), .alsu_red_op_B(rB),
      .alsu_bypass_A(bA), .alsu_bypass_B(bB), .alsu_direction(dir),
      .alsu_serial_in(sin), .alsu_cin(cin), .alsu_opcode(a_op[g]),
      .alsu_A(A), .alsu_B(B), .alsu_out(aout), .alsu_leds(leds)
    );

    always @(posedge clk) begin
      if (a_rst[g]) begin
        p_out <= '0;
        p_err <= '0;
      end else begin
        p_out[0] <= alsu_f(w_c, p_out[0]);
        p_err[0] <= alsu_e(w_c);
        for (int i = 1; i < LAT; i++) begin
          p_out[i] <= p_out[i-1];
          p_err[i] <= p_err[i-1];
        end
      end
    end
    assign aout = p_out[LAT-1];
    assign leds = p_err[LAT-1] ? 16'h00ff : 16'h0000;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic rdy(input int g, input int id);
    return id ? q1r[g] : q0r[g];
  endfunction
  function automatic logic rv(input int g, input int id);
    return id ? p1v[g] : p0v[g];
  endfunction

  task automatic set_req(input int g, input int id, input logic v, input logic [15:0] c);
    if (id != 0) begin r1v[g] = v; r1c[g] = c; end
    else         begin r0v[g] = v; r0c[g] = c; end
  endtask

  // Called at a negedge; returns at the negedge of the first response cycle
  task automatic run_op(input string tag, input int g, input int id, input logic [15:0] c,
                        input int exp_lat, input logic [5:0] exp_out, input logic exp_err);
    logic found, other;
    int   k;
    found = 1'b0;
    other = 1'b0;
    set_req(g, id, 1'b1, c);
    for (int w = 0; w < 40; w++) begin
      #1;
      if (rdy(g, id)) begin found = 1'b1; break; end
      @(negedge clk);
    end
    chk({tag, "_rdy"}, found, 1'b1);
    k = 0;
    do begin
      @(negedge clk);
      k++;
      if (k == 1) set_req(g, id, 1'b0, c);
      if (rv(g, 1 - id)) other = 1'b1;
    end while (!rv(g, id) && k < 40);
    chk({tag, "_lat"}, k, exp_lat);
    chk({tag, "_out"}, id ? o1[g] : o0[g], exp_out);
    chk({tag, "_err"}, id ? e1[g] : e0[g], exp_err);
    chk({tag, "_other"}, other, 1'b0);
  endtask

  // Both requesters valid continuously; log n grants, their ids and spacing
  task automatic grant_run(input string tag, input int g, input int n,
                           input logic [3:0] exp_ids, input int gap);
    int got, last;
    logic both;
    got = 0; last = 0; both = 1'b0;
    set_req(g, 0, 1'b1, mk(OP_ADD, 3'd1, 3'd1, 1'b0));
    set_req(g, 1, 1'b1, mk(OP_ADD, 3'd2, 3'd2, 1'b0));
    for (int k = 0; k < 80 && got < n; k++) begin
      #1;
      if (q0r[g] && q1r[g]) both = 1'b1;
      if (q0r[g] || q1r[g]) begin
        chk($sformatf("%s_id%0d", tag, got), q1r[g], exp_ids[got]);
        if (got > 0) chk($sformatf("%s_gap%0d", tag, got), cyc - last, gap);
        last = cyc;
        got++;
      end
      @(negedge clk);
    end
    chk({tag, "_count"}, got, n);
    chk({tag, "_excl"}, both, 1'b0);
    set_req(g, 0, 1'b0, '0);
    set_req(g, 1, 1'b0, '0);
    repeat (gap + 2) @(negedge clk);
  endtask

  initial begin
    // reset state, with req0 valid to show ready is held low
    r0v[0] = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_ready0", q0r[0], 1'b0);
    chk("rst_rspv0", p0v[0], 1'b0);
    chk("rst_out0", o0[0], 6'd0);
    chk("rst_alsu_rst", a_rst[0], 1'b1);
    chk("rst_alsu_op", a_op[0], 3'd0);
    r0v[0] = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("init_alsu_rst", a_rst[0], 1'b1);
    @(negedge clk);
    chk("idle_alsu_rst", a_rst[0], 1'b0);

    // ADD 3 + -2 -> 1 for req0
    run_op("add", 0, 0, mk(OP_ADD, 3'd3, 3'b110, 1'b0), 4, 6'd1, 1'b0);

    // MULT -4 * -4 -> 16 for req1, response back-pressured for 10 cycles
    s1r[0] = 1'b0;
    run_op("mul", 0, 1, mk(OP_MUL, 3'b100, 3'b100, 1'b0), 4, 6'd16, 1'b0);
    set_req(0, 0, 1'b1, mk(OP_ADD, 3'd1, 3'd1, 1'b0));
    for (int i = 0; i < 10; i++) begin
      #1;
      chk($sformatf("bp_v%0d", i), p1v[0], 1'b1);
      chk($sformatf("bp_o%0d", i), o1[0], 6'd16);
      chk($sformatf("bp_r%0d", i), q0r[0], 1'b0);
      @(negedge clk);
    end
    set_req(0, 0, 1'b0, '0);
    s1r[0] = 1'b1;
    @(negedge clk); #1;
    chk("bp_release", p1v[0], 1'b0);
    @(negedge clk);

    // last grant was req1 -> alternation starts with req0
    grant_run("rr", 0, 4, 4'b1010, 5);

    // invalid opcode from req0 while req1 waits; req1 granted after the handshake
    set_req(0, 1, 1'b1, mk(OP_OR, 3'd1, 3'd2, 1'b0));
    run_op("bad", 0, 0, mk(OP_BAD, 3'd1, 3'd1, 1'b0), 4, 6'd0, 1'b1);
    #1 chk("bad_hold_r1", q1r[0], 1'b0);
    @(negedge clk); #1;
    chk("bad_next_r1", q1r[0], 1'b1);
    chk("bad_rspv0", p0v[0], 1'b0);
    @(negedge clk);
    run_op("or_r1", 0, 1, mk(OP_OR, 3'd1, 3'd2, 1'b0), 4, 6'd3, 1'b0);
    @(negedge clk);

    // async reset during WAIT drops the command; pointer back to req0
    set_req(0, 0, 1'b1, mk(OP_ADD, 3'd1, 3'd2, 1'b0));
    #1 chk("mid_acc", q0r[0], 1'b1);
    @(negedge clk);
    set_req(0, 0, 1'b0, '0);
    @(negedge clk);
    r0v[0] = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rspv0", p0v[0], 1'b0);
    chk("mid_ready0", q0r[0], 1'b0);
    chk("mid_alsu_rst", a_rst[0], 1'b1);
    chk("mid_alsu_op", a_op[0], 3'd0);
    set_req(0, 0, 1'b0, '0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("mid_init", a_rst[0], 1'b1);
    chk("mid_no_rsp", p0v[0], 1'b0);
    set_req(0, 0, 1'b1, mk(OP_ADD, 3'd1, 3'd1, 1'b0));
    set_req(0, 1, 1'b1, mk(OP_ADD, 3'd2, 3'd2, 1'b0));
    @(negedge clk); #1;
    chk("mid_first_r0", q0r[0], 1'b1);
    chk("mid_first_r1", q1r[0], 1'b0);
    set_req(0, 1, 1'b0, '0);
    run_op("post", 0, 0, mk(OP_ADD, 3'd1, 3'd1, 1'b0), 4, 6'd2, 1'b0);
    @(negedge clk);

    // LAT=3, fixed priority instance
    run_op("lat3", 1, 0, mk(OP_OR, 3'd1, 3'd2, 1'b0), 5, 6'd3, 1'b0);
    @(negedge clk);
    grant_run("fix", 1, 3, 4'b0000, 6);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
